// File: rtl/vga_timing_if.sv
// Raster timing bundle between the VGA timing controller and the draw
// modules that consume it. The controller owns every signal except the
// run request.
interface vga_timing_if #(
    parameter int CNT_W  = 11,
    parameter int FCNT_W = 16
);
    logic              en;
    logic [CNT_W-1:0]  hcount;
    logic [CNT_W-1:0]  vcount;
    logic              hsync;
    logic              vsync;
    logic              hblnk;
    logic              vblnk;
    logic              line_start;
    logic              frame_start;
    logic [FCNT_W-1:0] frame_cnt;
    logic              busy;

    // Timing generator side: takes the run request, drives the raster.
    modport master (
        input  en,
        output hcount,
        output vcount,
        output hsync,
        output vsync,
        output hblnk,
        output vblnk,
        output line_start,
        output frame_start,
        output frame_cnt,
        output busy
    );

    // Consumer side: requests the raster and observes it.
    modport slave (
        output en,
        input  hcount,
        input  vcount,
        input  hsync,
        input  vsync,
        input  hblnk,
        input  vblnk,
        input  line_start,
        input  frame_start,
        input  frame_cnt,
        input  busy
    );
endinterface

// File: rtl/vga_timing_ctl.sv
// VGA raster timing controller (1440x900 @ 60 Hz by default).
// Generates pixel/line counters, syncs, blanking and line/frame strobes.
// Start and stop requests only take effect on frame boundaries, so a
// started frame is always completed. Every output is a register; the
// decodes are computed from the next-cycle counter values so that each
// decode lines up with the counters shown in the same cycle.
module vga_timing_ctl #(
    parameter int CNT_W       = 11,
    parameter int H_ACTIVE    = 1440,
    parameter int H_TOTAL     = 1600,
    parameter int HSYNC_START = 1487,
    parameter int HSYNC_STOP  = 1518,
    parameter int V_ACTIVE    = 900,
    parameter int V_TOTAL     = 926,
    parameter int VSYNC_START = 902,
    parameter int VSYNC_STOP  = 907,
    parameter int FCNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    vga_timing_if.master bus
);

    // Counter-width versions of the timing constants.
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(HSYNC_START);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(HSYNC_STOP);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(VSYNC_START);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(VSYNC_STOP);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Registered outputs and their next-cycle values.
    logic [CNT_W-1:0]  hcount_reg;
    logic [CNT_W-1:0]  hcount_next;
    logic [CNT_W-1:0]  vcount_reg;
    logic [CNT_W-1:0]  vcount_next;
    logic              hsync_reg;
    logic              hsync_next;
    logic              vsync_reg;
    logic              vsync_next;
    logic              hblnk_reg;
    logic              hblnk_next;
    logic              vblnk_reg;
    logic              vblnk_next;
    logic              line_start_reg;
    logic              line_start_next;
    logic              frame_start_reg;
    logic              frame_start_next;
    logic [FCNT_W-1:0] frame_cnt_reg;
    logic [FCNT_W-1:0] frame_cnt_next;
    logic              busy_reg;
    logic              busy_next;

    // Position flags for the pixel currently on the outputs.
    logic line_end;
    logic frame_end;
    logic running_now;
    logic running_next;
    logic new_frame;

    assign line_end     = (hcount_reg == H_LAST);
    assign frame_end    = line_end && (vcount_reg == V_LAST);
    assign running_now  = (state_reg != IDLE);
    assign running_next = (state_next != IDLE);

    // A frame begins either when leaving IDLE or when wrapping past the
    // last pixel while the raster keeps going.
    assign new_frame = running_next && (!running_now || frame_end);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: en is sampled each cycle, but leaving the running
    // states is only possible at the last pixel of a frame.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.en) begin
                    state_next = RUN;
                end
            end
            RUN, STOPPING: begin
                if (bus.en) begin
                    state_next = RUN;
                end else if (frame_end) begin
                    state_next = IDLE;
                end else begin
                    state_next = STOPPING;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counter advance: held at the origin whenever the raster is (or is
    // about to be) idle, and when the first frame after IDLE begins.
    always_comb begin
        hcount_next = '0;
        vcount_next = '0;
        if (running_now && running_next) begin
            if (line_end) begin
                hcount_next = '0;
                vcount_next = frame_end ? '0 : vcount_reg + 1'b1;
            end else begin
                hcount_next = hcount_reg + 1'b1;
                vcount_next = vcount_reg;
            end
        end
    end

    // Output decode from the next-cycle state and counters.
    always_comb begin
        hsync_next       = 1'b0;
        vsync_next       = 1'b0;
        hblnk_next       = 1'b1;
        vblnk_next       = 1'b1;
        line_start_next  = 1'b0;
        frame_start_next = 1'b0;
        busy_next        = 1'b0;
        frame_cnt_next   = frame_cnt_reg;
        if (running_next) begin
            hsync_next       = (hcount_next >= HS_FIRST) && (hcount_next <= HS_LAST);
            vsync_next       = (vcount_next >= VS_FIRST) && (vcount_next <= VS_LAST);
            hblnk_next       = (hcount_next >= H_ACT);
            vblnk_next       = (vcount_next >= V_ACT);
            line_start_next  = (hcount_next == '0);
            frame_start_next = new_frame;
            busy_next        = 1'b1;
        end
        if (new_frame) begin
            // Wraps silently from all-ones to zero.
            frame_cnt_next = frame_cnt_reg + 1'b1;
        end
    end

    // Output and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_reg      <= '0;
            vcount_reg      <= '0;
            hsync_reg       <= 1'b0;
            vsync_reg       <= 1'b0;
            hblnk_reg       <= 1'b1;
            vblnk_reg       <= 1'b1;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_cnt_reg   <= '0;
            busy_reg        <= 1'b0;
        end else begin
            hcount_reg      <= hcount_next;
            vcount_reg      <= vcount_next;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            hblnk_reg       <= hblnk_next;
            vblnk_reg       <= vblnk_next;
            line_start_reg  <= line_start_next;
            frame_start_reg <= frame_start_next;
            frame_cnt_reg   <= frame_cnt_next;
            busy_reg        <= busy_next;
        end
    end

    assign bus.hcount      = hcount_reg;
    assign bus.vcount      = vcount_reg;
    assign bus.hsync       = hsync_reg;
    assign bus.vsync       = vsync_reg;
    assign bus.hblnk       = hblnk_reg;
    assign bus.vblnk       = vblnk_reg;
    assign bus.line_start  = line_start_reg;
    assign bus.frame_start = frame_start_reg;
    assign bus.frame_cnt   = frame_cnt_reg;
    assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_vga_timing_ctl.sv
// Directed bench for vga_timing_ctl: default 1440x900 timing on the first
// lines, frame-aligned start/stop and async reset on a small raster, and
// frame counter wrap with a 2-bit counter.
module tb_vga_timing_ctl;

    logic clk;
    logic d_rst_n;
    logic s_rst_n;
    logic w_rst_n;

    int tests;
    int failed;

    vga_timing_if #(.CNT_W(11), .FCNT_W(16)) d_if ();
    vga_timing_if #(.CNT_W(11), .FCNT_W(16)) s_if ();
    vga_timing_if #(.CNT_W(11), .FCNT_W(2))  w_if ();

    // Default 1440x900 timing.
    vga_timing_ctl u_def (
        .clk   (clk),
        .rst_n (d_rst_n),
        .bus   (d_if.master)
    );

    // Small raster: 20x10 total, 12x6 active, hsync 14..15, vsync 7..8.
    vga_timing_ctl #(
        .CNT_W(11), .H_ACTIVE(12), .H_TOTAL(20), .HSYNC_START(14), .HSYNC_STOP(15),
        .V_ACTIVE(6), .V_TOTAL(10), .VSYNC_START(7), .VSYNC_STOP(8), .FCNT_W(16)
    ) u_small (
        .clk   (clk),
        .rst_n (s_rst_n),
        .bus   (s_if.master)
    );

    // Same small raster with a 2-bit frame counter.
    vga_timing_ctl #(
        .CNT_W(11), .H_ACTIVE(12), .H_TOTAL(20), .HSYNC_START(14), .HSYNC_STOP(15),
        .V_ACTIVE(6), .V_TOTAL(10), .VSYNC_START(7), .VSYNC_STOP(8), .FCNT_W(2)
    ) u_wrap (
        .clk   (clk),
        .rst_n (w_rst_n),
        .bus   (w_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int wrap_exp [4];

    initial begin
        tests    = 0;
        failed   = 0;
        wrap_exp = '{2, 3, 0, 1};
        d_rst_n  = 1'b0;
        s_rst_n  = 1'b0;
        w_rst_n  = 1'b0;
        d_if.en  = 1'b0;
        s_if.en  = 1'b0;
        w_if.en  = 1'b0;
        tick(3);

        // ---- Default timing: idle after reset ----
        d_rst_n = 1'b1;
        tick(100);
        $display("[TB] idle 100 clocks: h=%0d v=%0d busy=%0d", d_if.hcount, d_if.vcount, d_if.busy);
        chk("idle_hcount", d_if.hcount, 0);
        chk("idle_vcount", d_if.vcount, 0);
        chk("idle_hblnk", d_if.hblnk, 1);
        chk("idle_vblnk", d_if.vblnk, 1);
        chk("idle_hsync", d_if.hsync, 0);
        chk("idle_vsync", d_if.vsync, 0);
        chk("idle_busy", d_if.busy, 0);
        chk("idle_line_start", d_if.line_start, 0);
        chk("idle_frame_start", d_if.frame_start, 0);
        chk("idle_frame_cnt", d_if.frame_cnt, 0);

        // ---- Default timing: start and first line ----
        d_if.en = 1'b1;
        tick(1);
        $display("[TB] start: h=%0d v=%0d fs=%0d fc=%0d", d_if.hcount, d_if.vcount, d_if.frame_start, d_if.frame_cnt);
        chk("start_hcount", d_if.hcount, 0);
        chk("start_vcount", d_if.vcount, 0);
        chk("start_frame_start", d_if.frame_start, 1);
        chk("start_line_start", d_if.line_start, 1);
        chk("start_frame_cnt", d_if.frame_cnt, 1);
        chk("start_busy", d_if.busy, 1);
        chk("start_hblnk", d_if.hblnk, 0);
        chk("start_vblnk", d_if.vblnk, 0);
        tick(1);
        chk("h1_frame_start", d_if.frame_start, 0);
        chk("h1_line_start", d_if.line_start, 0);
        tick(1438);
        chk("h1439_hcount", d_if.hcount, 1439);
        chk("h1439_hblnk", d_if.hblnk, 0);
        tick(1);
        $display("[TB] h=%0d hblnk=%0d hsync=%0d", d_if.hcount, d_if.hblnk, d_if.hsync);
        chk("h1440_hblnk", d_if.hblnk, 1);
        chk("h1440_hsync", d_if.hsync, 0);
        tick(46);
        chk("h1486_hcount", d_if.hcount, 1486);
        chk("h1486_hsync", d_if.hsync, 0);
        tick(1);
        $display("[TB] h=%0d hsync=%0d", d_if.hcount, d_if.hsync);
        chk("h1487_hsync", d_if.hsync, 1);
        tick(31);
        chk("h1518_hcount", d_if.hcount, 1518);
        chk("h1518_hsync", d_if.hsync, 1);
        tick(1);
        $display("[TB] h=%0d hsync=%0d", d_if.hcount, d_if.hsync);
        chk("h1519_hsync", d_if.hsync, 0);
        tick(80);
        chk("h1599_hcount", d_if.hcount, 1599);
        chk("h1599_vcount", d_if.vcount, 0);
        tick(1);
        $display("[TB] line 1: h=%0d v=%0d ls=%0d fs=%0d", d_if.hcount, d_if.vcount, d_if.line_start, d_if.frame_start);
        chk("line1_hcount", d_if.hcount, 0);
        chk("line1_vcount", d_if.vcount, 1);
        chk("line1_line_start", d_if.line_start, 1);
        chk("line1_frame_start", d_if.frame_start, 0);
        d_rst_n = 1'b0;
        d_if.en = 1'b0;

        // ---- Small raster: start, vsync, frame period ----
        s_rst_n = 1'b1;
        tick(5);
        chk("s_idle_busy", s_if.busy, 0);
        s_if.en = 1'b1;
        tick(1);
        chk("s_start_frame_start", s_if.frame_start, 1);
        chk("s_start_frame_cnt", s_if.frame_cnt, 1);
        tick(139);
        chk("s_139_hcount", s_if.hcount, 19);
        chk("s_139_vcount", s_if.vcount, 6);
        chk("s_139_vsync", s_if.vsync, 0);
        chk("s_139_vblnk", s_if.vblnk, 1);
        tick(1);
        $display("[TB] small: h=%0d v=%0d vsync=%0d", s_if.hcount, s_if.vcount, s_if.vsync);
        chk("s_v7_vsync", s_if.vsync, 1);
        tick(14);
        chk("s_h14_hsync", s_if.hsync, 1);
        tick(26);
        chk("s_v9_vcount", s_if.vcount, 9);
        chk("s_v9_vsync", s_if.vsync, 0);
        tick(19);
        chk("s_last_frame_start", s_if.frame_start, 0);
        tick(1);
        $display("[TB] small frame 2: h=%0d v=%0d fs=%0d fc=%0d", s_if.hcount, s_if.vcount, s_if.frame_start, s_if.frame_cnt);
        chk("s_f2_frame_start", s_if.frame_start, 1);
        chk("s_f2_frame_cnt", s_if.frame_cnt, 2);
        chk("s_f2_vcount", s_if.vcount, 0);

        // ---- Small raster: drop en mid-frame, frame completes ----
        tick(50);
        s_if.en = 1'b0;
        tick(1);
        chk("s_stop_hcount", s_if.hcount, 11);
        chk("s_stop_busy", s_if.busy, 1);
        tick(148);
        chk("s_stop_last_h", s_if.hcount, 19);
        chk("s_stop_last_v", s_if.vcount, 9);
        chk("s_stop_last_busy", s_if.busy, 1);
        tick(1);
        $display("[TB] stopped: h=%0d v=%0d busy=%0d fc=%0d", s_if.hcount, s_if.vcount, s_if.busy, s_if.frame_cnt);
        chk("s_stopped_busy", s_if.busy, 0);
        chk("s_stopped_frame_start", s_if.frame_start, 0);
        chk("s_stopped_frame_cnt", s_if.frame_cnt, 2);
        chk("s_stopped_hblnk", s_if.hblnk, 1);

        // ---- Small raster: re-raise en inside STOPPING ----
        s_if.en = 1'b1;
        tick(1);
        chk("s_f3_frame_cnt", s_if.frame_cnt, 3);
        tick(30);
        s_if.en = 1'b0;
        tick(50);
        chk("s_stopping_busy", s_if.busy, 1);
        s_if.en = 1'b1;
        tick(119);
        chk("s_resume_last_h", s_if.hcount, 19);
        chk("s_resume_last_v", s_if.vcount, 9);
        tick(1);
        $display("[TB] resumed: h=%0d v=%0d fs=%0d fc=%0d", s_if.hcount, s_if.vcount, s_if.frame_start, s_if.frame_cnt);
        chk("s_resume_frame_start", s_if.frame_start, 1);
        chk("s_resume_frame_cnt", s_if.frame_cnt, 4);

        // ---- Small raster: en low only on the last pixel ----
        tick(199);
        chk("s_lp_hcount", s_if.hcount, 19);
        s_if.en = 1'b0;
        tick(1);
        $display("[TB] last-pixel drop: busy=%0d fs=%0d fc=%0d", s_if.busy, s_if.frame_start, s_if.frame_cnt);
        chk("s_lp_busy", s_if.busy, 0);
        chk("s_lp_frame_start", s_if.frame_start, 0);
        chk("s_lp_frame_cnt", s_if.frame_cnt, 4);
        s_if.en = 1'b1;
        tick(1);
        chk("s_lp_restart_fs", s_if.frame_start, 1);
        chk("s_lp_restart_fc", s_if.frame_cnt, 5);

        // ---- Small raster: async reset mid-line at (7,3) ----
        tick(67);
        chk("s_rst_pre_h", s_if.hcount, 7);
        chk("s_rst_pre_v", s_if.vcount, 3);
        s_rst_n = 1'b0;
        #1;
        $display("[TB] async reset: h=%0d v=%0d fc=%0d busy=%0d", s_if.hcount, s_if.vcount, s_if.frame_cnt, s_if.busy);
        chk("s_rst_hcount", s_if.hcount, 0);
        chk("s_rst_vcount", s_if.vcount, 0);
        chk("s_rst_frame_cnt", s_if.frame_cnt, 0);
        chk("s_rst_busy", s_if.busy, 0);
        chk("s_rst_hblnk", s_if.hblnk, 1);
        chk("s_rst_vblnk", s_if.vblnk, 1);
        #2;
        s_rst_n = 1'b1;
        tick(1);
        chk("s_rel_frame_start", s_if.frame_start, 1);
        chk("s_rel_frame_cnt", s_if.frame_cnt, 1);
        chk("s_rel_hcount", s_if.hcount, 0);
        s_rst_n = 1'b0;
        s_if.en = 1'b0;

        // ---- 2-bit frame counter wrap ----
        w_rst_n = 1'b1;
        w_if.en = 1'b1;
        tick(1);
        chk("w_fc_1", w_if.frame_cnt, 1);
        for (int k = 0; k < 4; k++) begin
            tick(200);
            $display("[TB] wrap frame %0d: fs=%0d fc=%0d", k + 2, w_if.frame_start, w_if.frame_cnt);
            chk("w_frame_start", w_if.frame_start, 1);
            chk("w_frame_cnt", w_if.frame_cnt, wrap_exp[k]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctl.md
Name: vga_timing_ctl

Overview:
- Sequences the VGA raster for the 1440x900 @ 60 Hz mode, using an 88.75 MHz pixel clock.
- Owns the horizontal and vertical counters, sync, blanking and frame/line strobes that all draw modules consume.
- Adds start/stop control that is aligned to frame boundaries, so the raster never starts or stops mid-frame, plus a frame counter for game-tick scheduling.

Parameters:
- CNT_W, 11, width of hcount/vcount; must hold H_TOTAL-1 and V_TOTAL-1.
- H_ACTIVE, 1440, visible pixels per line (hcount 0..1439).
- H_TOTAL, 1600, clocks per line (hcount 0..1599).
- HSYNC_START, 1487, first hcount with hsync asserted.
- HSYNC_STOP, 1518, last hcount with hsync asserted (inclusive).
- V_ACTIVE, 900, visible lines (vcount 0..899).
- V_TOTAL, 926, lines per frame (vcount 0..925).
- VSYNC_START, 902, first vcount with vsync asserted.
- VSYNC_STOP, 907, last vcount with vsync asserted (inclusive).
- FCNT_W, 16, frame counter width.

Ports:
- clk, in, 1, pixel clock.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, run request; level-sensitive.
- hcount, out, CNT_W, current pixel column.
- vcount, out, CNT_W, current line.
- hsync, out, 1, horizontal sync, active high.
- vsync, out, 1, vertical sync, active high.
- hblnk, out, 1, horizontal blanking (hcount >= H_ACTIVE).
- vblnk, out, 1, vertical blanking (vcount >= V_ACTIVE).
- line_start, out, 1, one-cycle pulse when hcount==0 while running.
- frame_start, out, 1, one-cycle pulse when hcount==0 && vcount==0 while running.
- frame_cnt, out, FCNT_W, number of frames started, modulo 2^FCNT_W.
- busy, out, 1, high in RUN or STOPPING.

Behaviour:
- Clock and reset: single clock domain, clk. rst_n is asynchronous and active low.
- All outputs are registers. In every cycle, hsync/vsync/hblnk/vblnk/line_start/frame_start describe the hcount/vcount presented in that same cycle. Implementation therefore decodes from next-state counter values.
- Reset values (also forced immediately when rst_n is asserted mid-operation):
  - state=IDLE, hcount=0, vcount=0, frame_cnt=0.
  - hsync=0, vsync=0, hblnk=1, vblnk=1.
  - line_start=0, frame_start=0, busy=0.
- FSM states: IDLE, RUN, STOPPING.
  - IDLE: counters held at 0, outputs at reset values except frame_cnt, which is held. en=1 sampled at a clock edge -> RUN. The cycle after that edge presents hcount=0, vcount=0, frame_start=1, line_start=1, busy=1, and frame_cnt incremented.
  - RUN: each cycle, hcount increments. At hcount==H_TOTAL-1, hcount wraps to 0 and vcount increments. At vcount==V_TOTAL-1 together with hcount==H_TOTAL-1, both counters wrap to 0 and a new frame starts (frame_start=1, frame_cnt+1). en=0 -> STOPPING; counting continues without interruption.
  - STOPPING: counts exactly as in RUN.
    - en=1 -> RUN, with no gap in the raster.
    - At the last pixel of a frame (hcount==H_TOTAL-1, vcount==V_TOTAL-1) with en=0 -> IDLE. The next cycle shows IDLE outputs, no frame_start, and frame_cnt unchanged.
    - At that same last pixel with en=1 -> RUN, and a new frame starts normally.
- Decodes, valid only in RUN/STOPPING:
  - hsync = HSYNC_START<=hcount<=HSYNC_STOP.
  - vsync = VSYNC_START<=vcount<=VSYNC_STOP.
  - hblnk = hcount>=H_ACTIVE.
  - vblnk = vcount>=V_ACTIVE.
- Timing at defaults:
  - Line period 1600 clocks; frame 1,481,600 clocks.
  - hsync width 32 clocks; vsync width 6 lines (9600 clocks).
- frame_cnt wraps from all-ones to 0 silently.
- en toggling within a frame never truncates that frame; only the frame-end decision point matters.
- After rst_n is released, the FSM is in IDLE; the first rising edge with en=1 starts a frame as described above.

Test Plan:
- Reset, en=0 for 100 clocks -> hcount=vcount=0, hblnk=vblnk=1, hsync=vsync=0, busy=0, no strobes.
- en=1 held, default params -> the cycle after the first sampling edge shows hcount=0, vcount=0, frame_start=1, frame_cnt=1. hsync rises at hcount=1487 and falls after 1518. hblnk rises at 1440. vsync spans vcount 902..907. Next frame_start arrives exactly 1,481,600 clocks later with frame_cnt=2.
- Small params (H_TOTAL=20, H_ACTIVE=12, V_TOTAL=10, V_ACTIVE=6): drop en mid-frame -> raster completes to (19,9), then IDLE, busy=0. Re-raise en within STOPPING -> no gap; the next frame starts at (0,0) on schedule.
- Small params, en driven low for exactly the last-pixel cycle only -> FSM goes to IDLE, frame_cnt unchanged. The en=1 seen at the next edge starts a new frame one cycle later.
- Assert rst_n low mid-line (hcount=7, vcount=3) -> all outputs take reset values asynchronously before the next clk edge, including frame_cnt=0. Release with en=1 -> restart from (0,0) with frame_cnt=1.
- FCNT_W=2, en=1 for 5 frames -> frame_cnt sequence 1,2,3,0,1.
